sampletest_tdm: RTL

SAMPLETEST_TDM -- requirements
Module: sampletest_tdm

---
 rtl/sampletest_pkg.sv | 17 +
 rtl/sampletest_tdm_if.sv | 34 +++
 rtl/sampletest_tdm_edge_eval.sv | 46 ++++
 rtl/sampletest_tdm.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sampletest_pkg.sv
// Shared types and helpers for the sampletest_tdm triangle sample tester.
package sampletest_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int EDGES = 3;

  // Edge distance is the difference of two full products, kept at double width.
  function automatic int dist_width(input int sigfig);
    return 2 * sigfig;
  endfunction

endpackage

// File: rtl/sampletest_tdm_if.sv
// Beat-level bus between a triangle source / result sink and sampletest_tdm.
interface sampletest_tdm_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
);
  // Both channels are valid/ready: a transfer happens on a rising edge where
  // valid && ready; the sender keeps valid and data steady until that edge,
  // and ready may depend combinationally on the receiver's state.
  logic                     in_valid;
  logic                     in_ready;
  logic signed [SIGFIG-1:0] tri_in       [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_in     [COLORS];
  logic signed [SIGFIG-1:0] sample_in    [2][SAMPS];
  logic        [SAMPS-1:0]  validSamp_in;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [SIGFIG-1:0] hit_out      [AXIS][SAMPS];
  logic        [SIGFIG-1:0] color_out    [COLORS];
  logic        [SAMPS-1:0]  hit_valid_out;

  modport master (
    output in_valid, tri_in, color_in, sample_in, validSamp_in, out_ready,
    input  in_ready, out_valid, hit_out, color_out, hit_valid_out
  );

  modport slave (
    input  in_valid, tri_in, color_in, sample_in, validSamp_in, out_ready,
    output in_ready, out_valid, hit_out, color_out, hit_valid_out
  );
endinterface

// File: rtl/sampletest_tdm_edge_eval.sv
// Combinational three-edge inside test for one sample against one triangle.
// SAMPLETEST_TWOSIDED_EN also accepts back-facing triangles (mirrored tie rule).
module edge_eval
  import sampletest_pkg::*;
#(
  parameter int SIGFIG = 24
) (
  input  logic signed [SIGFIG-1:0] i_vx [EDGES],
  input  logic signed [SIGFIG-1:0] i_vy [EDGES],
  input  logic signed [SIGFIG-1:0] i_sx,
  input  logic signed [SIGFIG-1:0] i_sy,
  input  logic                     i_valid,
  output logic                     o_hit
);
  localparam int DW = dist_width(SIGFIG);

  logic signed [SIGFIG-1:0] w_ax   [EDGES];
  logic signed [SIGFIG-1:0] w_ay   [EDGES];
  logic signed [DW-1:0]     w_dist [EDGES];
  logic [EDGES-1:0]         w_neg;
  logic [EDGES-1:0]         w_zero;
  logic                     w_front;
  logic                     w_side;

  for (genvar e = 0; e < EDGES; e++) begin : g_edge
    localparam int NX = (e + 1) % EDGES;
    assign w_ax[e]   = i_vx[e] - i_sx;
    assign w_ay[e]   = i_vy[e] - i_sy;
    assign w_dist[e] = DW'(w_ax[e]) * DW'(w_ay[NX]) - DW'(w_ax[NX]) * DW'(w_ay[e]);
    assign w_neg[e]  = w_dist[e][DW-1];
    assign w_zero[e] = (w_dist[e] == '0);
  end

  // Tie rule: points on e0 or e2 belong to the triangle, points on e1 do not.
  assign w_front = (w_neg[0] | w_zero[0]) & w_neg[1] & (w_neg[2] | w_zero[2]);

`ifdef SAMPLETEST_TWOSIDED_EN
  logic w_back;
  assign w_back = ~w_neg[0] & ~w_neg[1] & ~w_zero[1] & ~w_neg[2];
  assign w_side = w_front | w_back;
`else
  assign w_side = w_front;
`endif

  assign o_hit = i_valid & w_side;
endmodule

// File: rtl/sampletest_tdm.sv
// Time-multiplexed triangle sample tester: SAMPS samples through LANES edge units.
// Optional macro SAMPLETEST_TWOSIDED_EN enables two-sided (no back-face cull) hits.
module sampletest_tdm
  import sampletest_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4,
  parameter int LANES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sampletest_tdm_if.slave      bus,
  output state_t               o_dbg_state
);
  localparam int STEPS = SAMPS / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (VERTS != 3) begin : g_bad_verts
    $error("sampletest_tdm: VERTS must be 3");
  end
  if (SAMPS % LANES != 0) begin : g_bad_lanes
    $error("sampletest_tdm: SAMPS must be a multiple of LANES");
  end

  state_t                   r_state;
  state_t                   w_next;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [SIGFIG-1:0] r_tri   [VERTS][AXIS];
  logic        [SIGFIG-1:0] r_color [COLORS];
  logic signed [SIGFIG-1:0] r_samp  [2][SAMPS];
  logic [SAMPS-1:0]         r_vsamp;
  logic [SAMPS-1:0]         r_hit;
  logic [SAMPS-1:0]         w_hit_upd;
  logic                     w_in_ready;
  logic                     w_out_valid;
  logic                     w_accept;
  logic                     w_skip;
  logic                     w_last;

  assign w_skip = (bus.validSamp_in == '0);
  assign w_last = (r_cnt == CNT_W'(STEPS - 1));

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_EVAL: if (w_last) w_next = ST_HOLD;
      ST_HOLD: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (rst) w_in_ready = 1'b0;
    w_accept = bus.in_valid && w_in_ready;
    // A beat with no valid samples has nothing to test and goes straight to HOLD.
    if (w_accept) w_next = w_skip ? ST_HOLD : ST_EVAL;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_tri   <= '{default: '0};
      r_color <= '{default: '0};
      r_samp  <= '{default: '0};
      r_vsamp <= '0;
      r_hit   <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_tri   <= bus.tri_in;
      r_color <= bus.color_in;
      r_samp  <= bus.sample_in;
      r_vsamp <= bus.validSamp_in;
      r_hit   <= '0;
    end else if (r_state == ST_EVAL) begin
      r_cnt <= r_cnt + 1'b1;
      r_hit <= w_hit_upd;
    end
  end

  // Lane l tests sample r_cnt*LANES+l from the captured beat.
  logic signed [SIGFIG-1:0] w_cand_x [LANES][STEPS];
  logic signed [SIGFIG-1:0] w_cand_y [LANES][STEPS];
  logic                     w_cand_v [LANES][STEPS];
  logic signed [SIGFIG-1:0] w_vx [EDGES];
  logic signed [SIGFIG-1:0] w_vy [EDGES];
  logic [LANES-1:0]         w_lane_hit;

  for (genvar e = 0; e < EDGES; e++) begin : g_vert
    assign w_vx[e] = r_tri[e][0];
    assign w_vy[e] = r_tri[e][1];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar c = 0; c < STEPS; c++) begin : g_step
      assign w_cand_x[l][c] = r_samp[0][c*LANES+l];
      assign w_cand_y[l][c] = r_samp[1][c*LANES+l];
      assign w_cand_v[l][c] = r_vsamp[c*LANES+l];
    end

    edge_eval #(.SIGFIG(SIGFIG)) u_edge_eval (
      .i_vx    (w_vx),
      .i_vy    (w_vy),
      .i_sx    (w_cand_x[l][r_cnt]),
      .i_sy    (w_cand_y[l][r_cnt]),
      .i_valid (w_cand_v[l][r_cnt]),
      .o_hit   (w_lane_hit[l])
    );
  end

  for (genvar s = 0; s < SAMPS; s++) begin : g_samp
    localparam int C = s / LANES;
    localparam int L = s % LANES;
    assign w_hit_upd[s] = (r_cnt == CNT_W'(C)) ? w_lane_hit[L] : r_hit[s];

    for (genvar a = 0; a < AXIS; a++) begin : g_axis
      if (a < 2) begin : g_xy
        assign bus.hit_out[a][s] = r_samp[a][s];
      end else if (a == 2) begin : g_z
        assign bus.hit_out[a][s] = r_tri[0][2];
      end else begin : g_pad
        assign bus.hit_out[a][s] = '0;
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.color_out     = r_color;
  assign bus.hit_valid_out = r_hit;
  assign o_dbg_state       = r_state;
endmodule
